// File: rtl/serial_sub4_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub4_if
// Description : Start/done handshake bundle for the bit-serial subtractor.
//               The requester drives the operands and start, and the
//               subtractor returns busy, the done pulse and the result.
// Ports (modport slave, the subtractor side):
//   start  in   request, only looked at while the subtractor is idle
//   A      in   [WIDTH] minuend
//   B      in   [WIDTH] subtrahend
//   Bin    in   borrow-in
//   busy   out  operation in progress (SHIFT or DONE)
//   done   out  one-cycle completion pulse
//   D      out  [WIDTH] difference (A - B - Bin) mod 2^WIDTH
//   Bout   out  borrow-out, 1 when A < B + Bin
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_sub4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  // Requester side
  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout
  );

  // Subtractor side
  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout
  );
endinterface
`default_nettype wire

// File: rtl/serial_sub4.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub4
// Description : Bit-serial subtractor computing A - B - Bin over WIDTH
//               clock cycles, LSB first, with a single borrow cell and
//               operand shift registers. The result is held on D/Bout
//               until the next operation completes.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of serial_sub4_if (start, A, B, Bin in;
//              busy, done, D, Bout out)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  wire          clk,
  input  wire          rst,
  serial_sub4_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q,  a_sr_d;
  logic [WIDTH-1:0] b_sr_q,  b_sr_d;
  logic [WIDTH-1:0] r_sr_q,  r_sr_d;
  logic             br_q,    br_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             bout_q,  bout_d;

  // Single full-subtractor cell working on the current LSBs
  logic bit_a, bit_b, diff_bit, borrow_next;

  always_comb begin
    bit_a       = a_sr_q[0];
    bit_b       = b_sr_q[0];
    diff_bit    = bit_a ^ bit_b ^ br_q;
    borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.A;
          b_sr_d  = bus.B;
          br_d    = bus.Bin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        // Difference bits enter at the MSB so that after WIDTH shifts
        // bit 0 of the result sits at r_sr[0].
        r_sr_d = {diff_bit, r_sr_q[WIDTH-1:1]};
        br_d   = borrow_next;
        if (cnt_q == LAST_BIT) begin
          // Publish the finished word (including this last bit) on the
          // same edge. The counter is cleared rather than incremented so
          // it never needs a value of WIDTH.
          dout_d  = {diff_bit, r_sr_q[WIDTH-1:1]};
          bout_d  = borrow_next;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.D    = dout_q;
  assign bus.Bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub4.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub4
// Description : Self-checking bench for serial_sub4 (WIDTH = 4). Results are
//               predicted with plain integer arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub4;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  serial_sub4_if #(.WIDTH(WIDTH)) bus ();

  serial_sub4 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Last result the bench expects the DUT to be holding
  logic [WIDTH-1:0] last_d;
  logic             last_bo;

  // Reference: {borrow, difference} from integer subtraction
  function automatic logic [WIDTH:0] model(input int a, input int b, input int bin);
    int diff;
    logic [WIDTH-1:0] d;
    diff = a - b - bin;
    d    = diff[WIDTH-1:0];
    return {(diff < 0), d};
  endfunction

  // Runs one operation from IDLE and reports what was observed.
  // Operands are scrambled after acceptance to show they are not re-read.
  task automatic run_op(input int a, input int b, input int bin,
                        output int lat, output int busy_cyc, output int pulses,
                        output logic [WIDTH-1:0] d, output logic bo);
    lat = 0; busy_cyc = 0; pulses = 0; d = '0; bo = 1'b0;
    bus.start = 1'b1;
    bus.A     = WIDTH'(a);
    bus.B     = WIDTH'(b);
    bus.Bin   = bin[0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
    bus.Bin   = 1'($urandom);
    if (bus.busy) busy_cyc++;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          d   = bus.D;
          bo  = bus.Bout;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.Bout, bus.D} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b Bout=%b D=%0d, required all 0",
               bus.busy, bus.done, bus.Bout, bus.D);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.Bout, bus.D} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b Bout=%b D=%0d, required all 0",
               bus.busy, bus.done, bus.Bout, bus.D);
    end
    last_d = '0; last_bo = 1'b0;
  endtask

  task automatic test_basic();
    int ta [5] = '{9, 3, 0, 15, 15};
    int tb [5] = '{3, 9, 0, 15, 0};
    int tc [5] = '{0, 0, 1, 1, 0};
    int td [5] = '{6, 10, 15, 15, 15};
    int to [5] = '{0, 1, 1, 1, 0};
    int lat, bc, np;
    logic [WIDTH-1:0] d;
    logic bo;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, bc, np, d, bo);
      checks++;
      if (lat !== WIDTH) begin
        errors++;
        $display("FAIL basic_latency[%0d]: done after %0d edges, required %0d", i, lat, WIDTH);
      end
      checks++;
      if (np !== 1) begin
        errors++;
        $display("FAIL basic_done_pulses[%0d]: %0d pulses, required 1", i, np);
      end
      checks++;
      if (bc !== WIDTH + 1) begin
        errors++;
        $display("FAIL basic_busy_cycles[%0d]: %0d, required %0d", i, bc, WIDTH + 1);
      end
      checks++;
      if ({bo, d} !== {to[i][0], 4'(td[i])}) begin
        errors++;
        $display("FAIL basic_result[%0d]: D=%0d Bout=%b, required D=%0d Bout=%0d",
                 i, d, bo, td[i], to[i]);
      end
      checks++;
      if ({bus.Bout, bus.D} !== {to[i][0], 4'(td[i])} || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold[%0d]: D=%0d Bout=%b busy=%b, required D=%0d Bout=%0d busy=0",
                 i, bus.D, bus.Bout, bus.busy, td[i], to[i]);
      end
      last_d = 4'(td[i]); last_bo = to[i][0];
    end
  endtask

  task automatic test_ignore_start();
    int np = 0;
    int done_edge = 0;
    logic [WIDTH:0] exp = model(5, 2, 0);
    bus.start = 1'b1; bus.A = 4'd5; bus.B = 4'd2; bus.Bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      // Second request while shifting must be dropped
      if (k == 1) begin
        bus.start = 1'b1; bus.A = 4'd1; bus.B = 4'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        np++;
        done_edge = k;
        checks++;
        if ({bus.Bout, bus.D} !== exp) begin
          errors++;
          $display("FAIL ignore_result: D=%0d Bout=%b, required D=%0d Bout=%b",
                   bus.D, bus.Bout, exp[WIDTH-1:0], exp[WIDTH]);
        end
      end
    end
    checks++;
    if (np !== 1 || done_edge !== WIDTH) begin
      errors++;
      $display("FAIL ignore_single_done: %0d pulses last at edge %0d, required 1 at edge %0d",
               np, done_edge, WIDTH);
    end
    checks++;
    if ({bus.Bout, bus.D} !== exp || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_hold: D=%0d Bout=%b busy=%b, required D=%0d Bout=%b busy=0",
               bus.D, bus.Bout, bus.busy, exp[WIDTH-1:0], exp[WIDTH]);
    end
    last_d = exp[WIDTH-1:0]; last_bo = exp[WIDTH];
  endtask

  task automatic test_reset_mid();
    int np = 0;
    int lat, bc, pl;
    logic [WIDTH-1:0] d;
    logic bo;
    bus.start = 1'b1; bus.A = 4'd9; bus.B = 4'd3; bus.Bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.D !== last_d) begin
      errors++;
      $display("FAIL rstmid_before: busy=%b D=%0d, required busy=1 D=%0d", bus.busy, bus.D, last_d);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.Bout, bus.D} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: busy=%b done=%b Bout=%b D=%0d, required all 0",
               bus.busy, bus.done, bus.Bout, bus.D);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done) np++;
    end
    rst = 1'b0;
    repeat (WIDTH + 3) begin
      @(posedge clk); #1;
      if (bus.done) np++;
    end
    checks++;
    if (np !== 0 || bus.busy !== 1'b0 || {bus.Bout, bus.D} !== '0) begin
      errors++;
      $display("FAIL rstmid_no_done: pulses=%0d busy=%b D=%0d Bout=%b, required 0 0 0 0",
               np, bus.busy, bus.D, bus.Bout);
    end
    run_op(8, 8, 0, lat, bc, pl, d, bo);
    checks++;
    if (lat !== WIDTH || pl !== 1 || {bo, d} !== '0) begin
      errors++;
      $display("FAIL rstmid_after: lat=%0d pulses=%0d D=%0d Bout=%b, required lat=%0d pulses=1 D=0 Bout=0",
               lat, pl, d, bo, WIDTH);
    end
    last_d = '0; last_bo = 1'b0;
  endtask

  task automatic test_random();
    int a, b, c, lat, bc, pl;
    logic [WIDTH-1:0] d;
    logic bo;
    logic [WIDTH:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      c = int'($urandom_range(1, 0));
      exp = model(a, b, c);
      run_op(a, b, c, lat, bc, pl, d, bo);
      checks++;
      if (lat !== WIDTH || pl !== 1 || {bo, d} !== exp) begin
        errors++;
        $display("FAIL random[%0d] %0d-%0d-%0d: lat=%0d pulses=%0d D=%0d Bout=%b, required lat=%0d pulses=1 D=%0d Bout=%b",
                 i, a, b, c, lat, pl, d, bo, WIDTH, exp[WIDTH-1:0], exp[WIDTH]);
      end
      last_d = exp[WIDTH-1:0]; last_bo = exp[WIDTH];
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end
  endtask

  // start held high: each operation is accepted in the IDLE cycle that
  // follows DONE, so the pattern repeats every WIDTH+2 edges.
  task automatic test_back_to_back();
    logic [WIDTH:0] exp;
    logic [WIDTH:0] prev;
    prev = {last_bo, last_d};
    bus.start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.A   = 4'(i & 15);
      bus.B   = 4'((i >> 4) & 15);
      bus.Bin = 1'((i >> 8) & 1);
      exp = model(i & 15, (i >> 4) & 15, (i >> 8) & 1);
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || {bus.Bout, bus.D} !== prev) begin
        errors++;
        $display("FAIL b2b_accept[%0d]: busy=%b done=%b D=%0d Bout=%b, required busy=1 done=0 D=%0d Bout=%b",
                 i, bus.busy, bus.done, bus.D, bus.Bout, prev[WIDTH-1:0], prev[WIDTH]);
      end
      for (int k = 1; k <= WIDTH + 1; k++) begin
        bus.A   = WIDTH'($urandom);
        bus.B   = WIDTH'($urandom);
        bus.Bin = 1'($urandom);
        @(posedge clk); #1;
        if (k < WIDTH) begin
          checks++;
          if (bus.done !== 1'b0 || {bus.Bout, bus.D} !== prev) begin
            errors++;
            $display("FAIL b2b_hold[%0d.%0d]: done=%b D=%0d Bout=%b, required done=0 D=%0d Bout=%b",
                     i, k, bus.done, bus.D, bus.Bout, prev[WIDTH-1:0], prev[WIDTH]);
          end
        end else if (k == WIDTH) begin
          checks++;
          if (bus.done !== 1'b1 || {bus.Bout, bus.D} !== exp) begin
            errors++;
            $display("FAIL b2b_result[%0d]: done=%b D=%0d Bout=%b, required done=1 D=%0d Bout=%b",
                     i, bus.done, bus.D, bus.Bout, exp[WIDTH-1:0], exp[WIDTH]);
          end
        end else begin
          checks++;
          if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {bus.Bout, bus.D} !== exp) begin
            errors++;
            $display("FAIL b2b_idle[%0d]: busy=%b done=%b D=%0d, required busy=0 done=0 D=%0d",
                     i, bus.busy, bus.done, bus.D, exp[WIDTH-1:0]);
          end
        end
      end
      prev = exp;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || {bus.Bout, bus.D} !== prev) begin
      errors++;
      $display("FAIL b2b_final: busy=%b D=%0d Bout=%b, required busy=0 D=%0d Bout=%b",
               bus.busy, bus.D, bus.Bout, prev[WIDTH-1:0], prev[WIDTH]);
    end
    last_d = prev[WIDTH-1:0]; last_bo = prev[WIDTH];
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
